pipelined_sum_tree: RTL

//  Parametrised, pipelined N-operand unsigned adder, the successor to our flat
//  4x8-bit sum datapath. One balanced adder-tree level per register stage.

---
 rtl/pst_pkg.sv | 40 ++++
 rtl/pipelined_sum_tree_level.sv | 77 +++++++
 rtl/pipelined_sum_tree.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pst_pkg.sv
// ---------------------------------------------------------------------------
// pst_pkg
// Shared definitions for the pipelined sum tree:
//   pst_side_t      sideband flags that travel with each beat {acc, clr}
//   PST_SIDE_W      packed width of pst_side_t, used for port widths
//   pst_clog2       ceil(log2(n)); number of tree levels for n operands
//   pst_level_cnt   number of elements alive after k pairwise levels
//   pst_out_w       output / accumulator width for a given configuration
// ---------------------------------------------------------------------------
package pst_pkg;

  typedef struct packed {
    logic acc;  // beat joins the running accumulation
    logic clr;  // beat restarts the accumulation (only meaningful with acc)
  } pst_side_t;

  localparam int PST_SIDE_W = $bits(pst_side_t);

  function automatic int pst_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Each level halves the element count, rounding up: an odd element is
  // paired with an implicit zero.
  function automatic int pst_level_cnt(input int n_ops, input int k);
    int n;
    n = n_ops;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // One bit of growth per tree level, plus accumulator headroom.
  function automatic int pst_out_w(input int width, input int n_ops, input int acc_ext);
    return width + pst_clog2(n_ops) + acc_ext;
  endfunction

endpackage

// File: rtl/pipelined_sum_tree_level.sv
// ---------------------------------------------------------------------------
// pst_level
// One registered level of the balanced adder tree. Adjacent input elements
// are summed pairwise into results one bit wider; a trailing odd element is
// paired with zero so it passes through zero-extended. Valid and sideband
// flags are registered alongside the data. Everything holds when i_en is low.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears valid and sideband)
//   i_en     in   global pipeline advance
//   i_vld    in   incoming beat valid
//   i_side   in   incoming sideband flags (pst_side_t, packed)
//   i_data   in   N_IN packed elements of IN_W bits
//   o_vld    out  registered valid
//   o_side   out  registered sideband flags
//   o_data   out  ceil(N_IN/2) packed elements of IN_W+1 bits
// ---------------------------------------------------------------------------
module pst_level
  import pst_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int IN_W = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_en,
  input  logic                                  i_vld,
  input  logic [PST_SIDE_W-1:0]                 i_side,
  input  logic [N_IN*IN_W-1:0]                  i_data,
  output logic                                  o_vld,
  output logic [PST_SIDE_W-1:0]                 o_side,
  output logic [((N_IN+1)/2)*(IN_W+1)-1:0]      o_data
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int W_OUT = IN_W + 1;
  localparam int PAD_W = 2 * N_OUT * IN_W;

  logic [PAD_W-1:0]       w_pad;
  logic [N_OUT*W_OUT-1:0] w_sum;

  logic                   r_vld_p0;
  logic [PST_SIDE_W-1:0]  r_side_p0;
  logic [N_OUT*W_OUT-1:0] r_sum_p0;

  // Zero-extend to an even element count so every output is a plain pair sum.
  assign w_pad = PAD_W'(i_data);

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_sum[j*W_OUT +: W_OUT] = W_OUT'(w_pad[(2*j)*IN_W +: IN_W])
                              + W_OUT'(w_pad[(2*j+1)*IN_W +: IN_W]);
    end
  end

  // ---- stage boundary: level register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0  <= 1'b0;
      r_side_p0 <= '0;
    end else if (i_en) begin
      r_vld_p0  <= i_vld;
      r_side_p0 <= i_side;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) r_sum_p0 <= w_sum;
  end

  assign o_vld  = r_vld_p0;
  assign o_side = r_side_p0;
  assign o_data = r_sum_p0;

endmodule

// File: rtl/pipelined_sum_tree.sv
// ---------------------------------------------------------------------------
// pipelined_sum_tree
// Pipelined N_OPS-operand unsigned adder with one balanced tree level per
// register stage, a valid/ready handshake with a single global stall, and an
// optional running accumulator applied to beats leaving the last stage.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  beat accepted this cycle (= pipeline advance)
//   in_ops     in   N_OPS packed operands, op[i] = in_ops[i*WIDTH +: WIDTH]
//   in_acc     in   beat joins the running accumulation
//   in_clr     in   beat restarts the accumulation (ignored without in_acc)
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   out_sum    out  tree sum, or updated accumulator for acc beats
//   out_ovf    out  accumulator wrapped on this beat
// ---------------------------------------------------------------------------
module pipelined_sum_tree
  import pst_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int N_OPS   = 4,
  parameter  int ACC_EXT = 4,
  localparam int LVL     = pst_clog2(N_OPS),
  localparam int SUM_W   = WIDTH + LVL,
  localparam int OUT_W   = pst_out_w(WIDTH, N_OPS, ACC_EXT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] in_ops,
  input  logic                   in_acc,
  input  logic                   in_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   out_ovf
);

  // Modular add that also reports the carry out of OUT_W bits.
  function automatic logic [OUT_W:0] acc_wrap_add(input logic [OUT_W-1:0] a,
                                                  input logic [OUT_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic             w_adv;
  pst_side_t        w_side_in;
  logic             w_vld_out;
  pst_side_t        w_side_out;
  logic [SUM_W-1:0] w_tree_sum;
  logic [OUT_W-1:0] w_tree_ext;
  logic [OUT_W:0]   w_acc_add;
  logic [OUT_W-1:0] w_res;
  logic             w_ovf;

  logic [OUT_W-1:0] r_acc;

  // Every stage moves together; a held result stalls the whole tree.
  assign w_adv    = !w_vld_out || out_ready;
  assign in_ready = w_adv;

  assign w_side_in.acc = in_acc;
  assign w_side_in.clr = in_clr & in_acc;

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int NI = pst_level_cnt(N_OPS, k);
    localparam int WI = WIDTH + k;
    localparam int NO = pst_level_cnt(N_OPS, k + 1);
    localparam int WO = WI + 1;

    logic                  w_vin;
    logic [PST_SIDE_W-1:0] w_sin;
    logic [NI*WI-1:0]      w_din;
    logic                  w_vout;
    logic [PST_SIDE_W-1:0] w_sout;
    logic [NO*WO-1:0]      w_dout;

    if (k == 0) begin : g_head
      assign w_vin = in_valid;
      assign w_sin = w_side_in;
      assign w_din = in_ops;
    end else begin : g_link
      assign w_vin = g_lvl[k-1].w_vout;
      assign w_sin = g_lvl[k-1].w_sout;
      assign w_din = g_lvl[k-1].w_dout;
    end

    pst_level #(
      .N_IN (NI),
      .IN_W (WI)
    ) u_level (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_adv),
      .i_vld  (w_vin),
      .i_side (w_sin),
      .i_data (w_din),
      .o_vld  (w_vout),
      .o_side (w_sout),
      .o_data (w_dout)
    );
  end

  // The last tree level is the output register; the accumulator result is
  // formed from it and from r_acc, which holds the accumulation of all acc
  // beats that left before the one currently presented.
  assign w_vld_out  = g_lvl[LVL-1].w_vout;
  assign w_side_out = g_lvl[LVL-1].w_sout;
  assign w_tree_sum = g_lvl[LVL-1].w_dout;
  assign w_tree_ext = OUT_W'(w_tree_sum);
  assign w_acc_add  = acc_wrap_add(r_acc, w_tree_ext);

  always_comb begin
    w_res = w_tree_ext;
    w_ovf = 1'b0;
    if (w_side_out.acc && !w_side_out.clr) begin
      w_res = w_acc_add[OUT_W-1:0];
      w_ovf = w_acc_add[OUT_W];
    end
    if (!w_vld_out) begin
      w_res = '0;
      w_ovf = 1'b0;
    end
  end

  // ---- stage boundary: accumulator commit as the acc beat is handed off ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_adv && w_vld_out && w_side_out.acc) begin
      r_acc <= w_res;
    end
  end

  assign out_valid = w_vld_out;
  assign out_sum   = w_res;
  assign out_ovf   = w_ovf;

endmodule
